split_bus_arbiter: RTL and testbench
====================================

# split_bus_arbiter

Two-initiator arbiter for the shared serial bus, with split-transaction support. It decides which initiator drives the bus: the primary initiator, or the bus-bridge initiator on the downstream side. It parks an initiator whose target answered with a split acknowledgement. When the split target is ready to return data, it hands the bus back to that initiator. It sits between the initiator request lines and the bus address/data multiplexer select, one instance per bus segment.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 1024: maximum cycles one ownership may last without `trans_done` before a forced release.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req1  in  1  initiator 1 bus request; level, held until its transaction ends.
- req2  in  1  initiator 2 bus request; level, as `req1`.
- trans_done  in  1  one-cycle pulse from the bus: current transaction completed.
- split_start  in  1  one-cycle pulse: the addressed target issued a split acknowledgement.
- split_ready  in  1  level from the split target: read data ready; held until `split_grant`.
- grant1  out  1  bus owned by initiator 1 for a normal transaction.
- grant2  out  1  bus owned by initiator 2 for a normal transaction.
- split_grant  out  1  bus owned by the split target, returning data to `split_owner`.
- bus_sel  out  1  mux select: 0 = initiator 1, 1 = initiator 2; valid while `busy`.
- busy  out  1  any grant active.
- split_pending  out  2  bit i set means initiator i+1 is parked awaiting split data.
- timeout_err  out  1  one-cycle pulse on a forced release.
- split_err  out  1  one-cycle pulse when a second split is refused.

## Operation

- States: IDLE, GRANT1, GRANT2, SPLIT_RET. All outputs are registered and decoded from state and flags.
- Eligibility: an initiator is eligible when its `req` is high and its `split_pending` bit is clear.

IDLE:
- If `split_ready` is high and some `split_pending` bit is set, go to SPLIT_RET. `bus_sel` = owner of the split. This has priority over all requests.
- Otherwise, if both initiators are eligible, grant round-robin: the one not granted last wins. The `last` flag resets to 2, so initiator 1 wins the first tie.
- Otherwise grant the single eligible initiator.
- Otherwise stay in IDLE.
- `split_ready` with no pending split is ignored.

GRANTx:
- `trans_done` moves to IDLE and updates `last` to x.
- `split_start` sets `split_pending[x]`, records the owner, and moves to IDLE.
- If `split_start` and `trans_done` arrive together, `split_start` wins.
- If another split is already pending, `split_start` is treated as `trans_done` and `split_err` pulses.
- `req` falling without `trans_done` moves to IDLE (transaction abandoned).

SPLIT_RET:
- `trans_done` clears the owner's `split_pending` bit and moves to IDLE.

Timeout:
- Counts every cycle in GRANTx and SPLIT_RET; cleared on entry to IDLE.
- When the count reaches TIMEOUT_CYCLES−1 without an exit, move to IDLE and pulse `timeout_err`.
- A timeout in SPLIT_RET also clears the pending bit.
- Counter width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.

While a split is pending, the other initiator is still granted normally.

## Timing

- Reset: all outputs are 0. State IDLE, `last`=2, `split_pending`=00, counter 0. Asserting `rst` mid-transaction drops the grant the same cycle (asynchronously) and discards pending splits.
- Request sampled in IDLE at edge N: grant is high after edge N, i.e. visible in cycle N+1.
- `trans_done` or `split_start` sampled at edge M: grant is low in cycle M+1. The earliest next grant is M+2, so there is always at least one idle cycle between owners.
- `bus_sel` changes only on entry to a grant state; it holds its value in IDLE.
- Exactly one of `grant1`, `grant2`, `split_grant` is high when `busy`=1; none are high otherwise.
- Error pulses last exactly one cycle, coincident with the first IDLE cycle.

## Structure

- Package `split_bus_arb_pkg`:
  - `arb_state_t` enum (IDLE, GRANT1, GRANT2, SPLIT_RET).
  - Localparams `INIT1_ID`=0 and `INIT2_ID`=1.
- Sub-module `arb_timeout_ctr`: clear, enable, and terminal-count output, parameterised by TIMEOUT_CYCLES.

## Test plan

- **Single request:** `req1`=1 at cycle 5 → `grant1`=1 at cycle 6, `bus_sel`=0. `trans_done` at cycle 20 → `grant1`=0 at cycle 21, `busy`=0.
- **Contention:** `req1`=`req2`=1 continuously, `trans_done` every 8 cycles → grants alternate 1,2,1,2, with one idle cycle between each.
- **Split:**
  - `req1` granted, then `split_start` → `split_pending`=01, `grant1` drops.
  - `req2` is then granted while the split is pending.
  - After `req2`'s `trans_done`, raising `split_ready` → `split_grant`=1, `bus_sel`=0.
  - `trans_done` → `split_pending`=00.
- **Simultaneous events:** `split_start` and `trans_done` in the same cycle → split recorded. A second `split_start` from initiator 2 while 01 is pending → `split_err` pulse, `split_pending` stays 01.
- **Timeout:** TIMEOUT_CYCLES=16, `req2` held with no `trans_done` → `grant2` falls 16 cycles after rising, `timeout_err` pulses once.
- **Reset mid-grant:** `rst` asserted during SPLIT_RET → all outputs 0 immediately, `split_pending`=00. After release, `req1` is granted normally.

Source files
------------

// File: rtl/split_bus_arb_pkg.sv
// Shared definitions for the split-transaction bus arbiter.
//   arb_state_t : arbiter FSM states
//   INIT1_ID    : index/bus_sel value of initiator 1
//   INIT2_ID    : index/bus_sel value of initiator 2
package split_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT1,
        GRANT2,
        SPLIT_RET
    } arb_state_t;

    localparam logic INIT1_ID = 1'b0;
    localparam logic INIT2_ID = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Ownership watchdog for the split bus arbiter.
// Counts enabled cycles and flags the terminal count.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count this cycle
//   tc       : high while enabled and the count equals TIMEOUT_CYCLES-1
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturates at the terminal value so it can never wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-initiator arbiter for one shared serial bus segment with split support.
// Parks an initiator whose target issued a split acknowledgement and hands
// the bus to the split target when its read data is ready.
//   clk, rst      : clock, asynchronous active-high reset
//   req1, req2    : initiator bus requests (level)
//   trans_done    : pulse, current transaction completed
//   split_start   : pulse, target issued a split acknowledgement
//   split_ready   : level, split target has read data ready
//   grant1/grant2 : normal-transaction ownership by initiator 1/2
//   split_grant   : ownership by split target returning data
//   bus_sel       : mux select (0 = initiator 1, 1 = initiator 2), valid while busy
//   busy          : any grant active
//   split_pending : bit i = initiator i+1 parked awaiting split data
//   timeout_err   : one-cycle pulse on forced release
//   split_err     : one-cycle pulse when a second split is refused
module split_bus_arbiter
    import split_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       trans_done,
    input  logic       split_start,
    input  logic       split_ready,
    output logic       grant1,
    output logic       grant2,
    output logic       split_grant,
    output logic       bus_sel,
    output logic       busy,
    output logic [1:0] split_pending,
    output logic       timeout_err,
    output logic       split_err
);

    arb_state_t state;
    logic       last_id;
    logic       split_owner;
    logic       elig1;
    logic       elig2;
    logic       cur_id;
    logic       cur_req;
    logic       tmo_hit;
    logic       ctr_clr;
    logic       ctr_en;

    assign elig1   = req1 & ~split_pending[INIT1_ID];
    assign elig2   = req2 & ~split_pending[INIT2_ID];
    assign cur_id  = (state == GRANT2) ? INIT2_ID : INIT1_ID;
    assign cur_req = (state == GRANT2) ? req2 : req1;
    assign ctr_clr = (state == IDLE);
    assign ctr_en  = (state != IDLE);

    arb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk(clk),
        .rst(rst),
        .clr(ctr_clr),
        .en (ctr_en),
        .tc (tmo_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_id       <= INIT2_ID;
            split_owner   <= INIT1_ID;
            split_pending <= '0;
            grant1        <= 1'b0;
            grant2        <= 1'b0;
            split_grant   <= 1'b0;
            bus_sel       <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            split_err     <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            split_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (split_ready && (split_pending != '0)) begin
                        state       <= SPLIT_RET;
                        split_grant <= 1'b1;
                        busy        <= 1'b1;
                        bus_sel     <= split_owner;
                    end else if (elig1 && (!elig2 || (last_id == INIT2_ID))) begin
                        state   <= GRANT1;
                        grant1  <= 1'b1;
                        busy    <= 1'b1;
                        bus_sel <= INIT1_ID;
                    end else if (elig2) begin
                        state   <= GRANT2;
                        grant2  <= 1'b1;
                        busy    <= 1'b1;
                        bus_sel <= INIT2_ID;
                    end
                end

                GRANT1, GRANT2: begin
                    if (split_start || trans_done || !cur_req || tmo_hit) begin
                        state  <= IDLE;
                        grant1 <= 1'b0;
                        grant2 <= 1'b0;
                        busy   <= 1'b0;
                        if (split_start && (split_pending == '0)) begin
                            split_pending[cur_id] <= 1'b1;
                            split_owner           <= cur_id;
                        end else if (split_start || trans_done) begin
                            // A refused split completes like a normal transaction.
                            last_id   <= cur_id;
                            split_err <= split_start;
                        end else if (cur_req) begin
                            // No completion event and request still up: the watchdog fired.
                            timeout_err <= 1'b1;
                        end
                    end
                end

                SPLIT_RET: begin
                    if (trans_done || tmo_hit) begin
                        state                      <= IDLE;
                        split_grant                <= 1'b0;
                        busy                       <= 1'b0;
                        split_pending[split_owner] <= 1'b0;
                        timeout_err                <= !trans_done;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Scoreboard bench for split_bus_arbiter (TIMEOUT_CYCLES = 16).
// Stimulus pushes each expected output change with its cycle number; the
// monitor pops an entry whenever the sampled output vector changes.
module tb_split_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic       trans_done = 1'b0;
    logic       split_start = 1'b0;
    logic       split_ready = 1'b0;
    logic       grant1;
    logic       grant2;
    logic       split_grant;
    logic       bus_sel;
    logic       busy;
    logic [1:0] split_pending;
    logic       timeout_err;
    logic       split_err;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    // {grant1, grant2, split_grant, bus_sel, busy, split_pending[1:0], timeout_err, split_err}
    typedef struct {
        int         cyc;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];

    split_bus_arbiter #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req1         (req1),
        .req2         (req2),
        .trans_done   (trans_done),
        .split_start  (split_start),
        .split_ready  (split_ready),
        .grant1       (grant1),
        .grant2       (grant2),
        .split_grant  (split_grant),
        .bus_sel      (bus_sel),
        .busy         (busy),
        .split_pending(split_pending),
        .timeout_err  (timeout_err),
        .split_err    (split_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance to just after rising edge number c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(input int c, input logic g1, input logic g2, input logic sg,
                      input logic sel, input logic bsy, input logic [1:0] p,
                      input logic te, input logic se);
        exp_t e;
        e.cyc = c;
        e.v   = {g1, g2, sg, sel, bsy, p, te, se};
        q.push_back(e);
    endtask

    // Monitor: per-cycle grant exclusivity plus scoreboard on every output change.
    initial begin : monitor
        logic [8:0] cur;
        logic [8:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {grant1, grant2, split_grant, bus_sel, busy, split_pending, timeout_err, split_err};
            checks++;
            if ((busy != (grant1 | grant2 | split_grant)) ||
                ((int'(grant1) + int'(grant2) + int'(split_grant)) > 1)) begin
                errors++;
                $display("FAIL onehot cyc=%0d got g1=%0b g2=%0b sg=%0b busy=%0b want exactly one grant iff busy",
                         cyc, grant1, grant2, split_grant, busy);
            end
            if (cur != prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want no change", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if ((e.cyc != cyc) || (e.v != cur)) begin
                        errors++;
                        $display("FAIL event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                                 cyc, cur, e.cyc, e.v);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        // Reset state
        at(2);
        @(negedge clk);
        checks++;
        if ({grant1, grant2, split_grant, bus_sel, busy, split_pending, timeout_err, split_err} != 9'd0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b",
                     {grant1, grant2, split_grant, bus_sel, busy, split_pending, timeout_err, split_err}, 9'd0);
        end
        rst = 1'b0;

        // Single request
        at(5);  req1 = 1'b1;       ev(6,  1,0,0,0,1,2'b00,0,0);
        at(20); trans_done = 1'b1; ev(21, 0,0,0,0,0,2'b00,0,0);
        at(21); trans_done = 1'b0; req1 = 1'b0;

        // Contention: last owner was 1, so 2 wins the first tie here
        at(30); req1 = 1'b1; req2 = 1'b1; ev(31, 0,1,0,1,1,2'b00,0,0);
        at(38); trans_done = 1'b1; ev(39, 0,0,0,1,0,2'b00,0,0);
        at(39); trans_done = 1'b0; ev(40, 1,0,0,0,1,2'b00,0,0);
        at(47); trans_done = 1'b1; ev(48, 0,0,0,0,0,2'b00,0,0);
        at(48); trans_done = 1'b0; ev(49, 0,1,0,1,1,2'b00,0,0);
        at(56); trans_done = 1'b1; ev(57, 0,0,0,1,0,2'b00,0,0);
        at(57); trans_done = 1'b0; ev(58, 1,0,0,0,1,2'b00,0,0);
        at(65); trans_done = 1'b1; ev(66, 0,0,0,0,0,2'b00,0,0);
        at(66); trans_done = 1'b0; req1 = 1'b0; req2 = 1'b0;

        // Split with simultaneous trans_done, then refused second split
        at(70); req1 = 1'b1; ev(71, 1,0,0,0,1,2'b00,0,0);
        at(75); split_start = 1'b1; trans_done = 1'b1; ev(76, 0,0,0,0,0,2'b01,0,0);
        at(76); split_start = 1'b0; trans_done = 1'b0; req1 = 1'b0; req2 = 1'b1;
        ev(77, 0,1,0,1,1,2'b01,0,0);
        at(80); split_start = 1'b1; ev(81, 0,0,0,1,0,2'b01,0,1);
        at(81); split_start = 1'b0; req2 = 1'b0; ev(82, 0,0,0,1,0,2'b01,0,0);

        // Parked initiator 1 stays ineligible; 2 is granted, then split return
        at(85); req1 = 1'b1; req2 = 1'b1; ev(86, 0,1,0,1,1,2'b01,0,0);
        at(90); trans_done = 1'b1; ev(91, 0,0,0,1,0,2'b01,0,0);
        at(91); trans_done = 1'b0; req2 = 1'b0;
        at(93); split_ready = 1'b1; ev(94, 0,0,1,0,1,2'b01,0,0);
        at(94); split_ready = 1'b0;
        at(100); trans_done = 1'b1; ev(101, 0,0,0,0,0,2'b00,0,0);
        at(101); trans_done = 1'b0; ev(102, 1,0,0,0,1,2'b00,0,0);
        at(105); trans_done = 1'b1; ev(106, 0,0,0,0,0,2'b00,0,0);
        at(106); trans_done = 1'b0; req1 = 1'b0;

        // split_ready with nothing pending is ignored
        at(110); split_ready = 1'b1;
        at(113); split_ready = 1'b0;

        // Timeout in GRANT2: 16 cycles of ownership
        at(120); req2 = 1'b1; ev(121, 0,1,0,1,1,2'b00,0,0);
        ev(137, 0,0,0,1,0,2'b00,1,0);
        at(137); req2 = 1'b0; ev(138, 0,0,0,1,0,2'b00,0,0);

        // Timeout in SPLIT_RET clears the pending bit
        at(140); req1 = 1'b1; ev(141, 1,0,0,0,1,2'b00,0,0);
        at(143); split_start = 1'b1; ev(144, 0,0,0,0,0,2'b01,0,0);
        at(144); split_start = 1'b0; req1 = 1'b0; split_ready = 1'b1;
        ev(145, 0,0,1,0,1,2'b01,0,0);
        at(145); split_ready = 1'b0;
        ev(161, 0,0,0,0,0,2'b00,1,0);
        ev(162, 0,0,0,0,0,2'b00,0,0);

        // Reset during SPLIT_RET, then a normal grant
        at(165); req1 = 1'b1; ev(166, 1,0,0,0,1,2'b00,0,0);
        at(168); split_start = 1'b1; ev(169, 0,0,0,0,0,2'b01,0,0);
        at(169); split_start = 1'b0; req1 = 1'b0; split_ready = 1'b1;
        ev(170, 0,0,1,0,1,2'b01,0,0);
        at(170); split_ready = 1'b0;
        ev(172, 0,0,0,0,0,2'b00,0,0);
        at(172); rst = 1'b1;
        at(174); rst = 1'b0;
        at(176); req1 = 1'b1; ev(177, 1,0,0,0,1,2'b00,0,0);
        at(180); trans_done = 1'b1; ev(181, 0,0,0,0,0,2'b00,0,0);
        at(181); trans_done = 1'b0; req1 = 1'b0;

        at(190);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d outstanding want 0 (next cyc=%0d vec=%b)",
                     q.size(), q[0].cyc, q[0].v);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
